// File: rtl/serial_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// A zero divisor short-circuits straight to DONE with saturated quotient.
module serial_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rout_q, rout_d;
   logic             dbz_q, dbz_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             accept;
   logic             last_step;
   logic [WIDTH:0]   partial;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_dvd;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = (divisor == '0) ? DONE : RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (last_step) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy        = (state_q == RUN);
      done        = (state_q == DONE);
      quotient    = quot_q;
      remainder   = rout_q;
      div_by_zero = dbz_q;
   end

   // The dividend register doubles as the quotient shift register:
   // its MSB feeds the partial remainder while quotient bits enter at the LSB.
   always_comb begin
      accept    = start && (state_q != RUN);
      last_step = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
      partial   = {rem_q, dvd_q[WIDTH-1]};
      ge        = (partial >= {1'b0, dsr_q});
      diff      = partial - {1'b0, dsr_q};
      step_rem  = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
      step_dvd  = {dvd_q[WIDTH-2:0], ge};
   end

   always_comb begin
      dvd_d  = dvd_q;
      dsr_d  = dsr_q;
      rem_d  = rem_q;
      cnt_d  = cnt_q;
      quot_d = quot_q;
      rout_d = rout_q;
      dbz_d  = dbz_q;
      if (accept) begin
         dvd_d = dividend;
         dsr_d = divisor;
         rem_d = '0;
         cnt_d = '0;
         if (divisor == '0) begin
            quot_d = '1;
            rout_d = dividend;
            dbz_d  = 1'b1;
         end
      end else if (state_q == RUN) begin
         dvd_d = step_dvd;
         rem_d = step_rem;
         cnt_d = cnt_q + CW'(1);
         if (last_step) begin
            quot_d = step_dvd;
            rout_d = step_rem;
            dbz_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_q  <= '0;
         dsr_q  <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         quot_q <= '0;
         rout_q <= '0;
         dbz_q  <= 1'b0;
      end else begin
         dvd_q  <= dvd_d;
         dsr_q  <= dsr_d;
         rem_q  <= rem_d;
         cnt_q  <= cnt_d;
         quot_q <= quot_d;
         rout_q <= rout_d;
         dbz_q  <= dbz_d;
      end
   end

endmodule

// File: tb/tb_serial_divider.sv
// Scoreboard bench for serial_divider: expected results and completion cycle
// are queued at start time and checked when done pulses.
module tb_serial_divider;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   serial_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           due;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Called just after a falling edge; start is sampled on the next rising edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      exp_t x;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      if (push) begin
         if (b == '0) begin
            x.q = '1; x.r = a; x.z = 1'b1; x.due = cyc + 1;
         end else begin
            x.q = a / b; x.r = a % b; x.z = 1'b0; x.due = cyc + 1 + W;
         end
         sb.push_back(x);
      end
      @(negedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 200 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      #1;
      issue(a, b, 1'b1);
      wait_empty();
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_quot"}, 64'(quotient), 64'd0);
      check({tag, "_rem"},  64'(remainder), 64'd0);
      check({tag, "_dbz"},  64'(div_by_zero), 64'd0);
   endtask

   always @(negedge clk) begin
      if (sb.size() == 0) begin
         check("idle_done", 64'(done), 64'd0);
      end else if (done) begin
         e = sb.pop_front();
         check("quotient",  64'(quotient), 64'(e.q));
         check("remainder", 64'(remainder), 64'(e.r));
         check("dbz",       64'(div_by_zero), 64'(e.z));
         check("done_cycle", 64'(cyc), 64'(e.due));
         check("busy_in_done", 64'(busy), 64'd0);
         $display("txn cycle %0d: q=%08h r=%08h dbz=%0b (exp q=%08h r=%08h dbz=%0b)",
                  cyc, quotient, remainder, div_by_zero, e.q, e.r, e.z);
      end else if (cyc > sb[0].due) begin
         check("done_timing", 64'(cyc), 64'(sb[0].due));
         void'(sb.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #3;
      check_zero_outputs("reset");

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      // First edge after release must accept start.
      issue(32'd100, 32'd7, 1'b1);
      check("busy_run", 64'(busy), 64'd1);
      check("hold_quot", 64'(quotient), 64'd0);
      wait_empty();

      run_one(32'hFFFF_FFFF, 32'd1);
      run_one(32'h8000_0000, 32'hFFFF_FFFF);
      run_one(32'd0, 32'd17);
      run_one(32'd3, 32'd10);
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) run_one($urandom, $urandom_range(1, 1000));
         else            run_one($urandom, $urandom);
      end

      // Start pulsed mid-run must be ignored.
      @(negedge clk);
      #1;
      n0 = cyc + 1;
      issue(32'd100, 32'd7, 1'b1);
      while (cyc < n0 + 9) @(negedge clk);
      #1;
      start    = 1'b1;
      dividend = 32'd50;
      divisor  = 32'd5;
      @(negedge clk);
      #1;
      start = 1'b0;
      wait_empty();

      run_one(32'd5, 32'd0);

      // Asynchronous reset in the middle of a division: no done pulse.
      @(negedge clk);
      #1;
      n0 = cyc + 1;
      issue(32'd100, 32'd7, 1'b0);
      while (cyc < n0 + 14) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("midrun_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      issue(32'd1000, 32'd10, 1'b1);
      wait_empty();

      run_one(32'd9, 32'd3);

      // Start accepted while in DONE begins the next division immediately.
      @(negedge clk);
      #1;
      issue(32'd100, 32'd7, 1'b1);
      for (int i = 0; i < 100 && !done; i++) @(negedge clk);
      check("b2b_done", 64'(done), 64'd1);
      #1;
      issue(32'd21, 32'd4, 1'b1);
      wait_empty();

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
